// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared types and helpers for the Johnson code decoder
package johnson_pkg;

  // Sequence monitor states: locked once enough consecutive +1 steps are seen
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // Bits needed to hold a state number of a WIDTH-bit Johnson counter
  function automatic int idx_w(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// rtl/johnson_decoder_if.sv - sample/result bundle between the observed counter and the decoder
interface johnson_decoder_if
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8,
  localparam int IDX_W = idx_w(WIDTH)
);

  logic             in_valid;
  logic [WIDTH-1:0] code;
  logic             clear_err;
  logic             out_valid;
  logic [IDX_W-1:0] index;
  logic             code_err;
  logic             seq_err;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  modport master (
    output in_valid, code, clear_err,
    input  out_valid, index, code_err, seq_err, locked, err_count
  );

  modport slave (
    input  in_valid, code, clear_err,
    output out_valid, index, code_err, seq_err, locked, err_count
  );

endinterface

// File: rtl/johnson_index_decode.sv
// rtl/johnson_index_decode.sv - combinational legality check and state-number decode
module johnson_index_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [IDX_W-1:0] index
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [IDX_W:0]   TWO_W = (IDX_W + 1)'(2 * WIDTH);

  logic [WIDTH-1:0] thermo;
  logic [IDX_W:0]   pop;
  logic [IDX_W:0]   full;

  // Fold MSB=1 words onto the LSB-thermometer form; a thermometer plus one has no overlapping ones
  always_comb begin
    thermo = code[WIDTH-1] ? ~code : code;
    legal  = ((thermo & (thermo + ONE)) == '0);
    pop    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + (IDX_W + 1)'(code[i]);
    end
    full  = code[WIDTH-1] ? (TWO_W - pop) : pop;
    index = full[IDX_W-1:0];
  end

endmodule

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson counter decoder with sequence lock monitor and error counter
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8,
  localparam int IDX_W   = idx_w(WIDTH)
) (
  input logic              clk,
  input logic              rst_n,
  johnson_decoder_if.slave bus
);

  localparam int              RUN_W    = $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CNT);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  lock_state_t      state;
  logic             prev_valid;
  logic [IDX_W-1:0] prev_idx;
  logic [RUN_W-1:0] good_run;
  logic             out_valid_q;
  logic [IDX_W-1:0] index_q;
  logic             code_err_q;
  logic             seq_err_q;
  logic [ERR_W-1:0] err_count_q;

  logic             legal;
  logic [IDX_W-1:0] dec_idx;
  logic [IDX_W-1:0] step_idx;
  logic             is_hold;
  logic             is_step;
  logic             set_code_err;
  logic             set_seq_err;
  logic [RUN_W-1:0] run_next;

  johnson_index_decode #(.WIDTH(WIDTH)) u_decode (
    .code  (bus.code),
    .legal (legal),
    .index (dec_idx)
  );

  // Classify the sampled word against the previous state (hold, +1 with wrap, or jump)
  always_comb begin
    step_idx     = (prev_idx == LAST_IDX) ? '0 : prev_idx + IDX_ONE;
    is_hold      = prev_valid && (dec_idx == prev_idx);
    is_step      = prev_valid && (dec_idx == step_idx);
    set_code_err = bus.in_valid && !legal;
    set_seq_err  = bus.in_valid && legal && prev_valid && !is_hold && !is_step;
    run_next     = (good_run == RUN_MAX) ? RUN_MAX : good_run + RUN_ONE;
  end

  // Lock FSM, previous-state tracking and registered decode outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= UNLOCKED;
      prev_valid  <= 1'b0;
      prev_idx    <= '0;
      good_run    <= '0;
      out_valid_q <= 1'b0;
      index_q     <= '0;
      code_err_q  <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      code_err_q  <= set_code_err;
      seq_err_q   <= set_seq_err;
      if (bus.in_valid) begin
        if (!legal) begin
          prev_valid <= 1'b0;
          good_run   <= '0;
          state      <= UNLOCKED;
        end else begin
          index_q    <= dec_idx;
          prev_idx   <= dec_idx;
          prev_valid <= 1'b1;
          if (!prev_valid) begin
            good_run <= '0;
          end else if (is_hold) begin
            good_run <= good_run;
          end else if (is_step) begin
            good_run <= run_next;
            if (run_next == RUN_MAX) begin
              state <= LOCKED;
            end
          end else begin
            good_run <= '0;
            state    <= UNLOCKED;
          end
        end
      end
    end
  end

  // Saturating error counter; a clear wins over a same-cycle error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (bus.clear_err) begin
      err_count_q <= '0;
    end else if ((set_code_err || set_seq_err) && (err_count_q != '1)) begin
      err_count_q <= err_count_q + ERR_ONE;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.index     = index_q;
  assign bus.code_err  = code_err_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.locked    = (state == LOCKED);
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - vector-table bench for johnson_decoder
module tb_johnson_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  johnson_decoder_if #(.WIDTH(4), .ERR_W(8)) bus ();
  johnson_decoder_if #(.WIDTH(4), .ERR_W(2)) bus_s ();

  johnson_decoder #(.WIDTH(4), .LOCK_CNT(3), .ERR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  johnson_decoder #(.WIDTH(4), .LOCK_CNT(3), .ERR_W(2)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit       iv;
    bit [3:0] code;
    bit       clr;
    bit       ov;
    bit [2:0] idx;
    bit       ce;
    bit       se;
    bit       lk;
    bit [7:0] ec;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit iv, bit [3:0] code, bit clr, bit ov, bit [2:0] idx,
                              bit ce, bit se, bit lk, bit [7:0] ec);
    vec_t v;
    v.iv = iv; v.code = code; v.clr = clr; v.ov = ov; v.idx = idx;
    v.ce = ce; v.se = se; v.lk = lk; v.ec = ec;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input bit ov, input bit [2:0] idx,
                          input bit ce, input bit se, input bit lk, input bit [7:0] ec);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".index"},     32'(bus.index),     32'(idx));
    chk({tag, ".code_err"},  32'(bus.code_err),  32'(ce));
    chk({tag, ".seq_err"},   32'(bus.seq_err),   32'(se));
    chk({tag, ".locked"},    32'(bus.locked),    32'(lk));
    chk({tag, ".err_count"}, 32'(bus.err_count), 32'(ec));
  endtask

  task automatic drive_main(input bit iv, input bit [3:0] code, input bit clr);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.code      = code;
    bus.clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_small(input bit iv, input bit [3:0] code, input bit clr);
    @(negedge clk);
    bus_s.in_valid  = iv;
    bus_s.code      = code;
    bus_s.clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;   bus.code = 4'b0000;   bus.clear_err = 1'b0;
    bus_s.in_valid = 1'b0; bus_s.code = 4'b0000; bus_s.clear_err = 1'b0;

    // count up from zero and lock on index 3
    add(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
    add(1, 4'b0001, 0, 1, 1, 0, 0, 0, 0);
    add(1, 4'b0011, 0, 1, 2, 0, 0, 0, 0);
    add(1, 4'b0111, 0, 1, 3, 0, 0, 1, 0);
    // through the upper half and across the wrap, staying locked
    add(1, 4'b1111, 0, 1, 4, 0, 0, 1, 0);
    add(1, 4'b1110, 0, 1, 5, 0, 0, 1, 0);
    add(1, 4'b1100, 0, 1, 6, 0, 0, 1, 0);
    add(1, 4'b1000, 0, 1, 7, 0, 0, 1, 0);
    add(1, 4'b0000, 0, 1, 0, 0, 0, 1, 0);
    add(1, 4'b0001, 0, 1, 1, 0, 0, 1, 0);
    add(1, 4'b0011, 0, 1, 2, 0, 0, 1, 0);
    // held counter with sampling gaps
    for (int i = 0; i < 5; i++) begin
      add(0, 4'b0101, 0, 0, 2, 0, 0, 1, 0);
      add(1, 4'b0011, 0, 1, 2, 0, 0, 1, 0);
    end
    // illegal word drops lock and holds index, then relock on index 4
    add(1, 4'b0101, 0, 1, 2, 1, 0, 0, 1);
    add(1, 4'b0001, 0, 1, 1, 0, 0, 0, 1);
    add(1, 4'b0011, 0, 1, 2, 0, 0, 0, 1);
    add(1, 4'b0111, 0, 1, 3, 0, 0, 0, 1);
    add(1, 4'b1111, 0, 1, 4, 0, 0, 1, 1);
    add(1, 4'b1110, 0, 1, 5, 0, 0, 1, 1);
    add(1, 4'b1100, 0, 1, 6, 0, 0, 1, 1);
    add(1, 4'b1000, 0, 1, 7, 0, 0, 1, 1);
    add(1, 4'b0000, 0, 1, 0, 0, 0, 1, 1);
    add(1, 4'b0001, 0, 1, 1, 0, 0, 1, 1);
    // jump forward by two: sequence error
    add(1, 4'b0111, 0, 1, 3, 0, 1, 0, 2);
    // clear, then a backward step is also a sequence error
    add(0, 4'b0000, 1, 0, 3, 0, 0, 0, 0);
    add(1, 4'b0011, 0, 1, 2, 0, 1, 0, 1);
    add(1, 4'b0111, 0, 1, 3, 0, 0, 0, 1);
    add(1, 4'b1111, 0, 1, 4, 0, 0, 0, 1);
    add(1, 4'b1110, 0, 1, 5, 0, 0, 1, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_main("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.small_err_count", 32'(bus_s.err_count), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive_main(vecs[i].iv, vecs[i].code, vecs[i].clr);
      chk_main($sformatf("vec%0d", i), vecs[i].ov, vecs[i].idx, vecs[i].ce,
               vecs[i].se, vecs[i].lk, vecs[i].ec);
    end

    // reset lands in the middle of a sample cycle and acts at once
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.code     = 4'b0111;
    #2 rst_n = 1'b0;
    #1 chk_main("async_reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 chk_main("reset_held", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    // first legal word after reset has no previous state: no seq_err
    drive_main(1, 4'b0011, 0);
    chk_main("post_reset0", 1, 2, 0, 0, 0, 0);
    drive_main(1, 4'b0111, 0);
    chk_main("post_reset1", 1, 3, 0, 0, 0, 0);
    drive_main(0, 4'b0000, 0);

    // narrow error counter saturates, clear beats a same-cycle error
    drive_small(1, 4'b0101, 0);
    chk("sat0.err_count", 32'(bus_s.err_count), 32'd1);
    chk("sat0.code_err",  32'(bus_s.code_err),  32'd1);
    drive_small(1, 4'b1010, 0);
    chk("sat1.err_count", 32'(bus_s.err_count), 32'd2);
    drive_small(1, 4'b0110, 0);
    chk("sat2.err_count", 32'(bus_s.err_count), 32'd3);
    drive_small(1, 4'b1001, 0);
    chk("sat3.err_count", 32'(bus_s.err_count), 32'd3);
    chk("sat3.code_err",  32'(bus_s.code_err),  32'd1);
    drive_small(1, 4'b0101, 1);
    chk("clr.err_count",  32'(bus_s.err_count), 32'd0);
    chk("clr.code_err",   32'(bus_s.code_err),  32'd1);
    drive_small(1, 4'b0110, 0);
    chk("after_clr.err_count", 32'(bus_s.err_count), 32'd1);
    drive_small(0, 4'b0000, 0);
    chk("idle.out_valid", 32'(bus_s.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
